uart_regfile_v2: RTL and testbench

- Parametrised second-generation register file for the UART core.
- Bridges a simple cs/wen/addr bus to UART control and status signals.
- Adds beyond the first-generation block:
  - registered reads with a read-valid strobe;
  - DATA register with TX-push / RX-pop side effects;
  - baud divisor register;
  - maskable interrupt controller with write-1-to-clear (W1C) pending bits.

---
 rtl/uart_regfile_v2.sv | 173 +++++++++++++++++
 tb/tb_uart_regfile_v2.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_regfile_v2.sv
// rtl/uart_regfile_v2.sv - UART register file: CTRL/STATUS/DATA/INT/BAUD behind a cs/wen bus
// Registered reads, FIFO push/pop strobes, and W1C interrupt pending bits.
module uart_regfile_v2 #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 8,
  parameter int          LVL_W       = 5,
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [4:0]        word_length,
  output logic              num_stop_bits,
  output logic              oversample_by_3,
  output logic              enable_uart,
  output logic              parity_en,
  output logic              parity_odd,
  output logic [DIV_W-1:0]  baud_div,
  output logic              tx_push,
  output logic [7:0]        tx_wdata,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic [LVL_W-1:0]  tx_level,
  output logic              rx_pop,
  input  logic [7:0]        rx_rdata,
  input  logic              rx_empty,
  input  logic [LVL_W-1:0]  rx_level,
  input  logic              rx_overrun,
  input  logic              frame_err,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_INT_EN = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_PEND   = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(8'h14);

  logic [9:0]        ctrl_q, ctrl_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [5:0]        int_en_q, int_en_d;
  logic [5:0]        pend_q, pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              tx_push_q, tx_push_d;
  logic [7:0]        tx_wdata_q, tx_wdata_d;
  logic              rx_pop_q, rx_pop_d;
  logic              irq_q, irq_d;
  logic              tx_empty_q, tx_empty_d;

  logic              wr, rd;
  logic [5:0]        pend_set, pend_clr;
  logic [DATA_W-1:0] status;

  assign wr = cs & wen;
  assign rd = cs & ~wen;

  always_comb begin
    status                = '0;
    status[0]             = rx_empty;
    status[1]             = tx_full;
    status[2]             = tx_empty;
    status[8 +: LVL_W]    = rx_level;
    status[16 +: LVL_W]   = tx_level;
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    baud_d     = baud_q;
    int_en_d   = int_en_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    tx_push_d  = 1'b0;
    tx_wdata_d = tx_wdata_q;
    rx_pop_d   = 1'b0;
    pend_set   = {2'b00, frame_err, rx_overrun, tx_empty & ~tx_empty_q, ~rx_empty};
    pend_clr   = '0;

    if (wr) begin
      case (addr)
        A_CTRL:   ctrl_d = wdata[9:0];
        A_DATA: begin
          if (!tx_full) begin
            tx_push_d  = 1'b1;
            tx_wdata_d = wdata[7:0];
          end else begin
            pend_set[4] = 1'b1;
          end
        end
        A_INT_EN: int_en_d = wdata[5:0];
        A_PEND:   pend_clr = wdata[5:0];
        A_BAUD:   baud_d = wdata[DIV_W-1:0];
        default:  ;
      endcase
    end

    if (rd) begin
      rvalid_d = 1'b1;
      case (addr)
        A_CTRL:   rdata_d = DATA_W'(ctrl_q);
        A_STATUS: rdata_d = status;
        A_DATA: begin
          if (!rx_empty) begin
            rdata_d  = DATA_W'(rx_rdata);
            rx_pop_d = 1'b1;
          end else begin
            rdata_d     = '0;
            pend_set[5] = 1'b1;
          end
        end
        A_INT_EN: rdata_d = DATA_W'(int_en_q);
        A_PEND:   rdata_d = DATA_W'(pend_q);
        A_BAUD:   rdata_d = DATA_W'(baud_q);
        default:  rdata_d = '0;
      endcase
    end

    // Set is OR-ed in after the clear so a same-cycle event survives a W1C.
    pend_d     = (pend_q & ~pend_clr) | pend_set;
    irq_d      = |(pend_q & int_en_q);
    tx_empty_d = tx_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      baud_q     <= DIV_W'(DEFAULT_DIV);
      int_en_q   <= '0;
      pend_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      tx_push_q  <= 1'b0;
      tx_wdata_q <= '0;
      rx_pop_q   <= 1'b0;
      irq_q      <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      int_en_q   <= int_en_d;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      tx_push_q  <= tx_push_d;
      tx_wdata_q <= tx_wdata_d;
      rx_pop_q   <= rx_pop_d;
      irq_q      <= irq_d;
      tx_empty_q <= tx_empty_d;
    end
  end

  assign rdata           = rdata_q;
  assign rvalid          = rvalid_q;
  assign word_length     = ctrl_q[4:0];
  assign num_stop_bits   = ctrl_q[5];
  assign oversample_by_3 = ctrl_q[6];
  assign enable_uart     = ctrl_q[7];
  assign parity_en       = ctrl_q[8];
  assign parity_odd      = ctrl_q[9];
  assign baud_div        = baud_q;
  assign tx_push         = tx_push_q;
  assign tx_wdata        = tx_wdata_q;
  assign rx_pop          = rx_pop_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_uart_regfile_v2.sv
// tb/tb_uart_regfile_v2.sv - randomized and directed bench for uart_regfile_v2
module tb_uart_regfile_v2;

  logic        clk = 1'b0;
  logic        reset, cs, wen;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic        rvalid;
  logic [4:0]  word_length;
  logic        num_stop_bits, oversample_by_3, enable_uart, parity_en, parity_odd;
  logic [15:0] baud_div;
  logic        tx_push;
  logic [7:0]  tx_wdata;
  logic        tx_full, tx_empty;
  logic [4:0]  tx_level;
  logic        rx_pop;
  logic [7:0]  rx_rdata;
  logic        rx_empty;
  logic [4:0]  rx_level;
  logic        rx_overrun, frame_err, irq;

  int checks = 0;
  int failures = 0;

  uart_regfile_v2 dut (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .word_length(word_length),
    .num_stop_bits(num_stop_bits), .oversample_by_3(oversample_by_3),
    .enable_uart(enable_uart), .parity_en(parity_en), .parity_odd(parity_odd),
    .baud_div(baud_div), .tx_push(tx_push), .tx_wdata(tx_wdata),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level),
    .rx_pop(rx_pop), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
    .rx_level(rx_level), .rx_overrun(rx_overrun), .frame_err(frame_err), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference state: what software would see in each register.
  logic [9:0]  m_ctrl;
  logic [15:0] m_baud;
  logic [5:0]  m_inten, m_pend;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_push, m_pop, m_irq, m_last_txe;
  logic [7:0]  m_txw;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_view(input logic [7:0] a);
    case (a)
      8'h00:   return {22'd0, m_ctrl};
      8'h04:   return {11'd0, tx_level, 3'd0, rx_level, 5'd0, tx_empty, tx_full, rx_empty};
      8'h0C:   return {26'd0, m_inten};
      8'h10:   return {26'd0, m_pend};
      8'h14:   return {16'd0, m_baud};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    logic [5:0] events, clear;
    if (reset) begin
      m_ctrl = '0; m_baud = 16'd27; m_inten = '0; m_pend = '0;
      m_rdata = '0; m_rvalid = 0; m_push = 0; m_pop = 0; m_irq = 0;
      m_txw = '0; m_last_txe = 1;
      return;
    end
    events = 6'd0;
    clear  = 6'd0;
    m_irq    = (m_pend & m_inten) != 0;
    m_push   = 0;
    m_pop    = 0;
    m_rvalid = cs && !wen;
    if (cs && wen) begin
      if (addr == 8'h00) m_ctrl = wdata[9:0];
      if (addr == 8'h0C) m_inten = wdata[5:0];
      if (addr == 8'h10) clear = wdata[5:0];
      if (addr == 8'h14) m_baud = wdata[15:0];
      if (addr == 8'h08) begin
        if (tx_full) events[4] = 1;
        else begin m_push = 1; m_txw = wdata[7:0]; end
      end
    end
    if (cs && !wen) begin
      if (addr == 8'h08) begin
        if (rx_empty) begin m_rdata = 0; events[5] = 1; end
        else begin m_rdata = {24'd0, rx_rdata}; m_pop = 1; end
      end else m_rdata = reg_view(addr);
    end
    if (!rx_empty) events[0] = 1;
    if (tx_empty && !m_last_txe) events[1] = 1;
    if (rx_overrun) events[2] = 1;
    if (frame_err) events[3] = 1;
    m_pend = (m_pend & ~clear) | events;
    m_last_txe = tx_empty;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("rdata", rdata, m_rdata);
    check("rvalid", rvalid, m_rvalid);
    check("ctrl", {parity_odd, parity_en, enable_uart, oversample_by_3, num_stop_bits, word_length}, m_ctrl);
    check("baud_div", baud_div, m_baud);
    check("tx_push", tx_push, m_push);
    check("tx_wdata", tx_wdata, m_txw);
    check("rx_pop", rx_pop, m_pop);
    check("irq", irq, m_irq);
  endtask

  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d);
    cs = 1; wen = w; addr = a; wdata = d;
    cycle();
    cs = 0; wen = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [7:0] addr_tbl [8];

  initial begin
    reset = 1; cs = 0; wen = 0; addr = 0; wdata = 0;
    tx_full = 0; tx_empty = 1; tx_level = 0; rx_rdata = 0; rx_empty = 1;
    rx_level = 0; rx_overrun = 0; frame_err = 0;
    #1;
    idle(2);
    check("rst_baud", baud_div, 16'd27);
    check("rst_wl", word_length, 5'd0);
    check("rst_irq", irq, 1'b0);
    reset = 0;
    idle(1);

    bus(1'b0, 8'h14, 0);
    check("baud_read_rvalid", rvalid, 1'b1);
    check("baud_read_rdata", rdata, 32'd27);
    idle(1);
    check("rvalid_single", rvalid, 1'b0);

    bus(1'b1, 8'h00, 32'h3A8);
    check("wl8", word_length, 5'd8);
    check("en_uart", enable_uart, 1'b1);
    check("par_en", parity_en, 1'b1);
    check("par_odd", parity_odd, 1'b1);
    bus(1'b0, 8'h00, 0);
    check("ctrl_rb", rdata, 32'h3A8);

    bus(1'b1, 8'h08, 32'h1A5);
    check("push1", tx_push, 1'b1);
    check("push_data", tx_wdata, 8'hA5);
    idle(1);
    check("push_single", tx_push, 1'b0);
    tx_full = 1;
    bus(1'b1, 8'h08, 32'h1A5);
    check("no_push_full", tx_push, 1'b0);
    tx_full = 0;
    bus(1'b0, 8'h10, 0);
    check("pend_ovf", rdata, 32'h10);
    bus(1'b1, 8'h10, 32'h3F);

    rx_empty = 0; rx_rdata = 8'h3C;
    bus(1'b0, 8'h08, 0);
    check("rx_read", rdata, 32'h3C);
    check("rx_pop1", rx_pop, 1'b1);
    rx_empty = 1;
    bus(1'b0, 8'h08, 0);
    check("rx_empty_read", rdata, 32'h0);
    check("rx_no_pop", rx_pop, 1'b0);
    bus(1'b0, 8'h10, 0);
    check("underrun_bit", rdata[5], 1'b1);

    bus(1'b1, 8'h10, 32'h3F);
    bus(1'b1, 8'h0C, 32'h04);
    rx_overrun = 1;
    cycle();
    rx_overrun = 0;
    check("irq_lat1", irq, 1'b0);
    cycle();
    check("irq_lat2", irq, 1'b1);
    rx_overrun = 1;
    bus(1'b1, 8'h10, 32'h04);
    rx_overrun = 0;
    idle(2);
    check("set_wins", irq, 1'b1);
    bus(1'b1, 8'h10, 32'h04);
    idle(1);
    check("irq_clear", irq, 1'b0);

    bus(1'b1, 8'h0C, 32'h02);
    bus(1'b0, 8'h10, 0);
    check("no_txe_at_reset", rdata[1], 1'b0);
    tx_empty = 0;
    idle(2);
    tx_empty = 1;
    idle(1);
    bus(1'b0, 8'h10, 0);
    check("txe_rise", rdata[1], 1'b1);
    idle(1);
    check("txe_irq", irq, 1'b1);

    addr_tbl = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'hFF};
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom % 128) == 0;
      cs         = ($urandom % 3) != 0;
      wen        = $urandom % 2;
      addr       = addr_tbl[$urandom % 8];
      if (($urandom % 8) == 0) addr = 8'($urandom);
      wdata      = $urandom;
      tx_full    = ($urandom % 4) == 0;
      tx_empty   = ($urandom % 3) != 0;
      tx_level   = 5'($urandom);
      rx_rdata   = 8'($urandom);
      rx_empty   = ($urandom % 2) == 0;
      rx_level   = 5'($urandom);
      rx_overrun = ($urandom % 16) == 0;
      frame_err  = ($urandom % 16) == 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
